// File: rtl/crc_pkg.sv
// Shared definitions for the CRC stream checker: FSM state encoding and a
// bit-reverse helper used for output reflection.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        CMP   = 2'b10
    } crcState_t;

    localparam int MAX_CRC_WIDTH = 32;

    // Reverse the low 'width' bits of value; the result lands in the low bits.
    // The value is first left-aligned so every index below is a constant.
    function automatic logic [MAX_CRC_WIDTH-1:0] bitrev(
        input logic [MAX_CRC_WIDTH-1:0] value,
        input int                       width
    );
        logic [MAX_CRC_WIDTH-1:0] aligned;
        logic [MAX_CRC_WIDTH-1:0] result;
        aligned = value << (MAX_CRC_WIDTH - width);
        result  = {MAX_CRC_WIDTH{1'b0}};
        for (int i = 0; i < MAX_CRC_WIDTH; i++) begin
            result[i] = aligned[MAX_CRC_WIDTH-1-i];
        end
        return result;
    endfunction

endpackage

// File: rtl/crc_word_step.sv
// Combinational one-word CRC update: MSB-first bit-serial CRC over DWIDTH bits,
// fully unrolled. Optional per-byte input reflection. Shared with the TX generator.
module crc_word_step
    import crc_pkg::*;
#(
    parameter int CRC_WIDTH = 16,
    parameter int DWIDTH    = 32
) (
    input  logic [CRC_WIDTH-1:0] crcIn,
    input  logic [DWIDTH-1:0]    dataIn,
    input  logic [CRC_WIDTH-1:0] poly,
    input  logic                 refIn,
    output logic [CRC_WIDTH-1:0] crcOut
);

    logic [DWIDTH-1:0]    wordRefl_s;
    logic [DWIDTH-1:0]    word_s;
    logic [CRC_WIDTH-1:0] crcWork_s;
    logic                 fb_s;

    // Select the data word, optionally reversing bit order inside each byte.
    always_comb begin
        wordRefl_s = {DWIDTH{1'b0}};
        for (int b = 0; b < DWIDTH / 8; b++) begin
            for (int k = 0; k < 8; k++) begin
                wordRefl_s[b*8 + k] = dataIn[b*8 + 7 - k];
            end
        end
        if (refIn) begin
            word_s = wordRefl_s;
        end else begin
            word_s = dataIn;
        end
    end

    // Shift every data bit through the CRC register, first wire bit (MSB) first.
    always_comb begin
        crcWork_s = crcIn;
        fb_s      = 1'b0;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            fb_s = crcWork_s[CRC_WIDTH-1] ^ word_s[i];
            if (fb_s) begin
                crcWork_s = {crcWork_s[CRC_WIDTH-2:0], 1'b0} ^ poly;
            end else begin
                crcWork_s = {crcWork_s[CRC_WIDTH-2:0], 1'b0};
            end
        end
        crcOut = crcWork_s;
    end

endmodule

// File: rtl/crc_stream_checker.sv
// Receive-side CRC verifier: accumulates a frame over a valid/ready stream and
// pulses a pass/fail verdict one cycle after the last word.
// Optional feature macro: CRC_CHK_ERRCNT_EN adds a saturating failed-frame
// counter (errCnt) with a synchronous clear (errCntClr).
module crc_stream_checker
    import crc_pkg::*;
#(
    parameter int CRC_WIDTH = 16,
    parameter int DWIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dataValid,
    output logic                 dataReady,
    input  logic [DWIDTH-1:0]    dataIn,
    input  logic                 dataLast,
    input  logic [CRC_WIDTH-1:0] crcRx,
    input  logic [CRC_WIDTH-1:0] genPoly,
    input  logic [CRC_WIDTH-1:0] initValue,
    input  logic                 refInEn,
    input  logic                 refOutEn,
    input  logic [CRC_WIDTH-1:0] finalXorValue,
    output logic                 chkDone,
    output logic                 chkPass,
    output logic [CRC_WIDTH-1:0] crcCalc,
    output logic                 busy
`ifdef CRC_CHK_ERRCNT_EN
    ,
    input  logic                 errCntClr,
    output logic [15:0]          errCnt
`endif
);

    crcState_t            state_r, nextState_s;
    logic [CRC_WIDTH-1:0] crcReg_r, polyReg_r, finalXorReg_r, crcRxReg_r, crcCalc_r;
    logic                 refInReg_r, refOutReg_r;
    logic                 dataReady_r, busy_r, chkDone_r, chkPass_r;
    logic                 accept_s;
    logic [CRC_WIDTH-1:0] stepCrcIn_s, stepPoly_s, stepOut_s, postCrc_s;
    logic                 stepRefIn_s;
    logic [MAX_CRC_WIDTH-1:0] revFull_s;

    assign accept_s = dataValid & dataReady_r;

    // The first word of a frame uses the live config; later words use the latched copy.
    always_comb begin
        if (state_r == IDLE) begin
            stepCrcIn_s = initValue;
            stepPoly_s  = genPoly;
            stepRefIn_s = refInEn;
        end else begin
            stepCrcIn_s = crcReg_r;
            stepPoly_s  = polyReg_r;
            stepRefIn_s = refInReg_r;
        end
    end

    crc_word_step #(
        .CRC_WIDTH (CRC_WIDTH),
        .DWIDTH    (DWIDTH)
    ) uStep (
        .crcIn  (stepCrcIn_s),
        .dataIn (dataIn),
        .poly   (stepPoly_s),
        .refIn  (stepRefIn_s),
        .crcOut (stepOut_s)
    );

    // Next-state logic for the IDLE -> ACCUM -> CMP frame sequence.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    nextState_s = dataLast ? CMP : ACCUM;
                end else begin
                    nextState_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s && dataLast) begin
                    nextState_s = CMP;
                end else begin
                    nextState_s = ACCUM;
                end
            end
            CMP:     nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Post-process the accumulated CRC: optional full reversal, then final XOR.
    always_comb begin
        revFull_s = bitrev(MAX_CRC_WIDTH'(crcReg_r), CRC_WIDTH);
        if (refOutReg_r) begin
            postCrc_s = revFull_s[CRC_WIDTH-1:0] ^ finalXorReg_r;
        end else begin
            postCrc_s = crcReg_r ^ finalXorReg_r;
        end
    end

    // State, handshake and status registers; ready/busy are registered from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            dataReady_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= nextState_s;
            dataReady_r <= (nextState_s != CMP);
            busy_r      <= (nextState_s != IDLE);
        end
    end

    // CRC accumulator plus per-frame config and received-CRC latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crcReg_r      <= {CRC_WIDTH{1'b0}};
            polyReg_r     <= {CRC_WIDTH{1'b0}};
            finalXorReg_r <= {CRC_WIDTH{1'b0}};
            crcRxReg_r    <= {CRC_WIDTH{1'b0}};
            refInReg_r    <= 1'b0;
            refOutReg_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                crcReg_r <= stepOut_s;
            end
            if (accept_s && (state_r == IDLE)) begin
                polyReg_r     <= genPoly;
                finalXorReg_r <= finalXorValue;
                refInReg_r    <= refInEn;
                refOutReg_r   <= refOutEn;
            end
            if (accept_s && dataLast) begin
                crcRxReg_r <= crcRx;
            end
        end
    end

    // Verdict registers: one-cycle strobe, pass flag and held computed CRC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chkDone_r <= 1'b0;
            chkPass_r <= 1'b0;
            crcCalc_r <= {CRC_WIDTH{1'b0}};
        end else begin
            chkDone_r <= (state_r == CMP);
            if (state_r == CMP) begin
                crcCalc_r <= postCrc_s;
                chkPass_r <= (postCrc_s == crcRxReg_r);
            end
        end
    end

    assign dataReady = dataReady_r;
    assign busy      = busy_r;
    assign chkDone   = chkDone_r;
    assign chkPass   = chkPass_r;
    assign crcCalc   = crcCalc_r;

`ifdef CRC_CHK_ERRCNT_EN
    logic [15:0] errCnt_r;

    // Saturating failed-frame counter; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errCnt_r <= 16'h0000;
        end else if (errCntClr) begin
            errCnt_r <= 16'h0000;
        end else if (chkDone_r && !chkPass_r && (errCnt_r != 16'hFFFF)) begin
            errCnt_r <= errCnt_r + 16'h0001;
        end
    end

    assign errCnt = errCnt_r;
`endif

endmodule

// File: tb/tb_crc_stream_checker.sv
// Directed bench for crc_stream_checker: a 16-bit and a 32-bit instance (DWIDTH=8)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_crc_stream_checker;

    logic        clk;
    logic        rst;
    logic        dataValid;
    logic [7:0]  dataIn;
    logic        dataLast;
    logic [31:0] crcRx, genPoly, initValue, finalXorValue;
    logic        refInEn, refOutEn;

    logic        ready16, done16, pass16, busy16;
    logic [15:0] calc16;
    logic        ready32, done32, pass32, busy32;
    logic [31:0] calc32;
`ifdef CRC_CHK_ERRCNT_EN
    logic        errCntClr;
    logic [15:0] errCnt16, errCnt32;
`endif

    logic [7:0] msg [9];
    int  checks;
    int  fails;
    bit  readyLowSeen;
    bit  doneSeen;

    crc_stream_checker #(.CRC_WIDTH(16), .DWIDTH(8)) dut16 (
        .clk(clk), .rst(rst), .dataValid(dataValid), .dataReady(ready16),
        .dataIn(dataIn), .dataLast(dataLast), .crcRx(crcRx[15:0]),
        .genPoly(genPoly[15:0]), .initValue(initValue[15:0]),
        .refInEn(refInEn), .refOutEn(refOutEn), .finalXorValue(finalXorValue[15:0]),
        .chkDone(done16), .chkPass(pass16), .crcCalc(calc16), .busy(busy16)
`ifdef CRC_CHK_ERRCNT_EN
        , .errCntClr(errCntClr), .errCnt(errCnt16)
`endif
    );

    crc_stream_checker #(.CRC_WIDTH(32), .DWIDTH(8)) dut32 (
        .clk(clk), .rst(rst), .dataValid(dataValid), .dataReady(ready32),
        .dataIn(dataIn), .dataLast(dataLast), .crcRx(crcRx),
        .genPoly(genPoly), .initValue(initValue),
        .refInEn(refInEn), .refOutEn(refOutEn), .finalXorValue(finalXorValue),
        .chkDone(done32), .chkPass(pass32), .crcCalc(calc32), .busy(busy32)
`ifdef CRC_CHK_ERRCNT_EN
        , .errCntClr(errCntClr), .errCnt(errCnt32)
`endif
    );

    always #5 clk = ~clk;

    // Drive words 0..nWords-1 of "123456789", called at a negedge; returns just after
    // the posedge that accepts the last driven word. dataLast marks word 8.
    task automatic drive_frame(input int nWords, input int gapAt, input int gapLen, input bit scramble);
        for (int i = 0; i < nWords; i++) begin
            if (i == gapAt) begin
                dataValid = 1'b0;
                repeat (gapLen) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (ready16 !== 1'b1) readyLowSeen = 1'b1;
                end
            end
            dataValid = 1'b1;
            dataIn    = msg[i];
            dataLast  = (i == 8);
            if (ready16 !== 1'b1) readyLowSeen = 1'b1;
            @(posedge clk);
            if (i < nWords - 1) @(negedge clk);
            if (scramble && i == 0) begin
                genPoly       = 32'h0000_0000;
                initValue     = 32'h1234_5678;
                refInEn       = ~refInEn;
                refOutEn      = ~refOutEn;
                finalXorValue = 32'hA5A5_A5A5;
            end
        end
    endtask

    task automatic cfg_ccitt();
        genPoly = 32'h0000_1021; initValue = 32'h0000_FFFF; refInEn = 1'b0; refOutEn = 1'b0;
        finalXorValue = 32'h0000_0000; crcRx = 32'h0000_29B1;
    endtask

    task automatic cfg_arc(input logic [31:0] rx);
        genPoly = 32'h0000_8005; initValue = 32'h0000_0000; refInEn = 1'b1; refOutEn = 1'b1;
        finalXorValue = 32'h0000_0000; crcRx = rx;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 6;
        if (ready16 !== 1'b1)      begin fails++; $display("FAIL reset_ready: got %b expected 1", ready16); end
        if (done16 !== 1'b0)       begin fails++; $display("FAIL reset_done: got %b expected 0", done16); end
        if (pass16 !== 1'b0)       begin fails++; $display("FAIL reset_pass: got %b expected 0", pass16); end
        if (calc16 !== 16'h0000)   begin fails++; $display("FAIL reset_calc16: got %h expected 0000", calc16); end
        if (busy16 !== 1'b0)       begin fails++; $display("FAIL reset_busy: got %b expected 0", busy16); end
        if (calc32 !== 32'h0)      begin fails++; $display("FAIL reset_calc32: got %h expected 00000000", calc32); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ccitt();
        cfg_ccitt();
        drive_frame(9, -1, 0, 1'b0);
        @(negedge clk);
        dataValid = 1'b0;
        checks += 3;
        if (done16 !== 1'b0)  begin fails++; $display("FAIL ccitt_early_done: got %b expected 0", done16); end
        if (ready16 !== 1'b0) begin fails++; $display("FAIL ccitt_cmp_ready: got %b expected 0", ready16); end
        if (busy16 !== 1'b1)  begin fails++; $display("FAIL ccitt_cmp_busy: got %b expected 1", busy16); end
        @(negedge clk);
        checks += 4;
        if (done16 !== 1'b1)     begin fails++; $display("FAIL ccitt_done: got %b expected 1", done16); end
        if (pass16 !== 1'b1)     begin fails++; $display("FAIL ccitt_pass: got %b expected 1", pass16); end
        if (calc16 !== 16'h29B1) begin fails++; $display("FAIL ccitt_calc: got %h expected 29b1", calc16); end
        if (ready16 !== 1'b1)    begin fails++; $display("FAIL ccitt_ready_back: got %b expected 1", ready16); end
        @(negedge clk);
        checks += 2;
        if (done16 !== 1'b0)     begin fails++; $display("FAIL ccitt_done_pulse: got %b expected 0", done16); end
        if (calc16 !== 16'h29B1) begin fails++; $display("FAIL ccitt_calc_hold: got %h expected 29b1", calc16); end
    endtask

    task automatic test_arc();
        cfg_arc(32'h0000_BB3D);
        drive_frame(9, -1, 0, 1'b0);
        @(negedge clk); dataValid = 1'b0;
        @(negedge clk);
        checks += 3;
        if (done16 !== 1'b1)     begin fails++; $display("FAIL arc_done: got %b expected 1", done16); end
        if (pass16 !== 1'b1)     begin fails++; $display("FAIL arc_pass: got %b expected 1", pass16); end
        if (calc16 !== 16'hBB3D) begin fails++; $display("FAIL arc_calc: got %h expected bb3d", calc16); end
        cfg_arc(32'h0000_BB3C);
        drive_frame(9, -1, 0, 1'b0);
        @(negedge clk); dataValid = 1'b0;
        @(negedge clk);
        checks += 3;
        if (done16 !== 1'b1)     begin fails++; $display("FAIL arc_bad_done: got %b expected 1", done16); end
        if (pass16 !== 1'b0)     begin fails++; $display("FAIL arc_bad_pass: got %b expected 0", pass16); end
        if (calc16 !== 16'hBB3D) begin fails++; $display("FAIL arc_bad_calc: got %h expected bb3d", calc16); end
    endtask

    task automatic test_crc32();
        genPoly = 32'h04C1_1DB7; initValue = 32'hFFFF_FFFF; refInEn = 1'b1; refOutEn = 1'b1;
        finalXorValue = 32'hFFFF_FFFF; crcRx = 32'hCBF4_3926;
        drive_frame(9, -1, 0, 1'b0);
        @(negedge clk); dataValid = 1'b0;
        @(negedge clk);
        checks += 3;
        if (done32 !== 1'b1)          begin fails++; $display("FAIL crc32_done: got %b expected 1", done32); end
        if (pass32 !== 1'b1)          begin fails++; $display("FAIL crc32_pass: got %b expected 1", pass32); end
        if (calc32 !== 32'hCBF43926)  begin fails++; $display("FAIL crc32_calc: got %h expected cbf43926", calc32); end
    endtask

    task automatic test_gap();
        cfg_ccitt();
        readyLowSeen = 1'b0;
        drive_frame(9, 4, 3, 1'b1);
        @(negedge clk); dataValid = 1'b0;
        @(negedge clk);
        checks += 4;
        if (done16 !== 1'b1)       begin fails++; $display("FAIL gap_done: got %b expected 1", done16); end
        if (pass16 !== 1'b1)       begin fails++; $display("FAIL gap_pass: got %b expected 1", pass16); end
        if (calc16 !== 16'h29B1)   begin fails++; $display("FAIL gap_calc: got %h expected 29b1", calc16); end
        if (readyLowSeen !== 1'b0) begin fails++; $display("FAIL gap_ready_low: got %b expected 0", readyLowSeen); end
    endtask

    task automatic test_back_to_back();
        cfg_arc(32'h0000_BB3D);
        drive_frame(9, -1, 0, 1'b0);
        @(negedge clk); dataValid = 1'b0;
        @(negedge clk);
        checks += 3;
        if (done16 !== 1'b1)  begin fails++; $display("FAIL b2b_first_done: got %b expected 1", done16); end
        if (pass16 !== 1'b1)  begin fails++; $display("FAIL b2b_first_pass: got %b expected 1", pass16); end
        if (ready16 !== 1'b1) begin fails++; $display("FAIL b2b_ready_on_done: got %b expected 1", ready16); end
        cfg_ccitt();
        drive_frame(9, -1, 0, 1'b0);
        @(negedge clk); dataValid = 1'b0;
        @(negedge clk);
        checks += 3;
        if (done16 !== 1'b1)     begin fails++; $display("FAIL b2b_second_done: got %b expected 1", done16); end
        if (pass16 !== 1'b1)     begin fails++; $display("FAIL b2b_second_pass: got %b expected 1", pass16); end
        if (calc16 !== 16'h29B1) begin fails++; $display("FAIL b2b_second_calc: got %h expected 29b1", calc16); end
    endtask

    task automatic test_abort();
        cfg_ccitt();
        drive_frame(5, -1, 0, 1'b0);
        @(negedge clk);
        dataValid = 1'b0;
        rst = 1'b1;
        #1;
        checks += 3;
        if (busy16 !== 1'b0)     begin fails++; $display("FAIL abort_busy: got %b expected 0", busy16); end
        if (ready16 !== 1'b1)    begin fails++; $display("FAIL abort_ready: got %b expected 1", ready16); end
        if (calc16 !== 16'h0000) begin fails++; $display("FAIL abort_calc: got %h expected 0000", calc16); end
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done16 !== 1'b0) doneSeen = 1'b1;
        end
        checks += 1;
        if (doneSeen !== 1'b0) begin fails++; $display("FAIL abort_no_done: got %b expected 0", doneSeen); end
        drive_frame(9, -1, 0, 1'b0);
        @(negedge clk); dataValid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (done16 !== 1'b1) begin fails++; $display("FAIL abort_fresh_done: got %b expected 1", done16); end
        if (pass16 !== 1'b1) begin fails++; $display("FAIL abort_fresh_pass: got %b expected 1", pass16); end
    endtask

`ifdef CRC_CHK_ERRCNT_EN
    task automatic test_errcnt();
        errCntClr = 1'b1;
        @(negedge clk);
        errCntClr = 1'b0;
        checks += 1;
        if (errCnt16 !== 16'd0) begin fails++; $display("FAIL errcnt_clear0: got %0d expected 0", errCnt16); end
        cfg_arc(32'h0000_BB3C);
        repeat (2) begin
            drive_frame(9, -1, 0, 1'b0);
            @(negedge clk); dataValid = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
        checks += 1;
        if (errCnt16 !== 16'd2) begin fails++; $display("FAIL errcnt_two: got %0d expected 2", errCnt16); end
        errCntClr = 1'b1;
        @(negedge clk);
        errCntClr = 1'b0;
        checks += 1;
        if (errCnt16 !== 16'd0) begin fails++; $display("FAIL errcnt_clear: got %0d expected 0", errCnt16); end
    endtask
`endif

    initial begin
        clk = 1'b0; rst = 1'b1; dataValid = 1'b0; dataIn = 8'h00; dataLast = 1'b0;
        crcRx = 32'h0; genPoly = 32'h0; initValue = 32'h0; finalXorValue = 32'h0;
        refInEn = 1'b0; refOutEn = 1'b0;
`ifdef CRC_CHK_ERRCNT_EN
        errCntClr = 1'b0;
`endif
        checks = 0; fails = 0; readyLowSeen = 1'b0; doneSeen = 1'b0;
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);

        test_reset();
        test_ccitt();
        test_arc();
        test_crc32();
        test_gap();
        test_back_to_back();
        test_abort();
`ifdef CRC_CHK_ERRCNT_EN
        test_errcnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
